// File: rtl/chord_pkg.sv
// Shared definitions for the chord scheduler: FSM states, datapath widths
// and the 16-bit saturation limits used when CHORD_SAT_EN is defined.
package chord_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int STEP_W   = 20;
    localparam int SAMPLE_W = 16;
    localparam int ACC_W    = 18;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 18'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -18'sd32768;

endpackage

// File: rtl/chord_scheduler_mix_round.sv
// Converts the 18-bit signed mix accumulator to the 16-bit output sample.
// Build option CHORD_SAT_EN: saturate to the 16-bit range; otherwise the
// accumulator is arithmetically shifted right by 2 and truncated.
module mix_round
    import chord_pkg::*;
(
    input  logic signed [ACC_W-1:0]    acc,
    output logic signed [SAMPLE_W-1:0] mix
);

`ifdef CHORD_SAT_EN
    // Clamp the accumulator into the signed 16-bit range
    always_comb begin
        if (acc > SAT_MAX) begin
            mix = SAMPLE_W'(SAT_MAX);
        end else if (acc < SAT_MIN) begin
            mix = SAMPLE_W'(SAT_MIN);
        end else begin
            mix = SAMPLE_W'(acc);
        end
    end
`else
    // Scale down by 4 so a full chord of voices cannot wrap the output
    always_comb begin
        mix = SAMPLE_W'(acc >>> 2);
    end
`endif

endmodule

// File: rtl/chord_scheduler.sv
// Chord scheduler: on each codec request, pulses the enabled sine-reader
// voices one at a time, sums their samples and delivers one mixed sample.
// Build option CHORD_SAT_EN selects saturation in mix_round instead of >>>2.
module chord_scheduler
    import chord_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int TIMEOUT    = 4
)
(
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           sample_req,
    input  logic [NUM_VOICES-1:0]          voice_en,
    input  logic                           load_en,
    input  logic [1:0]                     load_idx,
    input  logic [STEP_W-1:0]              load_step,
    output logic [NUM_VOICES*STEP_W-1:0]   step_size,
    output logic [NUM_VOICES-1:0]          gen_next,
    input  logic [NUM_VOICES-1:0]          voice_ready,
    input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
    output logic [SAMPLE_W-1:0]            mix_sample,
    output logic                           mix_valid,
    output logic                           busy,
    output logic                           overrun,
    output logic                           timeout_err,
    input  logic                           err_clr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t                   state, state_nxt;
    logic [1:0]               idx, idx_nxt;
    logic [NUM_VOICES-1:0]    en_mask, en_mask_nxt;
    logic signed [ACC_W-1:0]  acc, acc_nxt;
    logic [CNT_W-1:0]         wait_cnt, wait_cnt_nxt;
    logic                     timeout_hit;
    logic                     overrun_hit;
    logic                     sel_ready;
    logic [SAMPLE_W-1:0]      sel_sample;
    logic [2:0]               first_pick, next_pick;
    logic signed [SAMPLE_W-1:0] mix_value;

    // Lowest enabled voice at or above start; bit 2 flags that one was found
    function automatic logic [2:0] find_voice(input logic [NUM_VOICES-1:0] mask,
                                              input logic [2:0] start);
        logic [2:0] pick;
        pick = 3'b000;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= start)) begin
                pick = {1'b1, 2'(i)};
            end
        end
        return pick;
    endfunction

    // Route the ready pulse and sample of the currently selected voice
    always_comb begin
        sel_ready  = 1'b0;
        sel_sample = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (idx == 2'(i)) begin
                sel_ready  = voice_ready[i];
                sel_sample = voice_sample[i*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // Next-state, accumulation and strobe outputs of the sequencing FSM
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        en_mask_nxt  = en_mask;
        acc_nxt      = acc;
        wait_cnt_nxt = wait_cnt;
        timeout_hit  = 1'b0;
        first_pick   = find_voice(voice_en, 3'd0);
        next_pick    = find_voice(en_mask, {1'b0, idx} + 3'd1);
        busy         = (state != IDLE);
        mix_valid    = (state == DONE);
        overrun_hit  = sample_req && (state != IDLE);
        gen_next     = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            gen_next[i] = (state == ISSUE) && (idx == 2'(i));
        end

        case (state)
            IDLE: begin
                if (sample_req) begin
                    en_mask_nxt = voice_en;
                    acc_nxt     = '0;
                    idx_nxt     = first_pick[1:0];
                    state_nxt   = first_pick[2] ? ISSUE : DONE;
                end
            end
            ISSUE: begin
                wait_cnt_nxt = '0;
                state_nxt    = WAIT;
            end
            WAIT: begin
                if (sel_ready || (wait_cnt == CNT_LAST)) begin
                    if (sel_ready) begin
                        acc_nxt = acc + {{(ACC_W-SAMPLE_W){sel_sample[SAMPLE_W-1]}}, sel_sample};
                    end else begin
                        timeout_hit = 1'b1;
                    end
                    if (next_pick[2]) begin
                        idx_nxt   = next_pick[1:0];
                        state_nxt = ISSUE;
                    end else begin
                        state_nxt = DONE;
                    end
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM registers, the mixed output sample and the sticky status flags
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            en_mask     <= '0;
            acc         <= '0;
            wait_cnt    <= '0;
            mix_sample  <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            en_mask  <= en_mask_nxt;
            acc      <= acc_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (state_nxt == DONE) begin
                mix_sample <= mix_value;
            end
            if (overrun_hit) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    // Per-voice step registers; writes to nonexistent voices fall through
    always_ff @(posedge clk) begin
        if (!reset) begin
            step_size <= '0;
        end else begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (load_en && (load_idx == 2'(i))) begin
                    step_size[i*STEP_W +: STEP_W] <= load_step;
                end
            end
        end
    end

    mix_round u_mix_round (
        .acc (acc_nxt),
        .mix (mix_value)
    );

endmodule

// File: tb/tb_chord_scheduler.sv
// Self-checking bench for chord_scheduler with a 2-cycle-latency sine-reader
// model and an event scoreboard (gen_next pulses and mix results by cycle).
// Honours CHORD_SAT_EN in its reference mix model.
module tb_chord_scheduler;

    localparam int NV      = 3;
    localparam int TIMEOUT = 4;

    typedef struct packed {
        logic        kind;
        logic [15:0] cycle;
        logic [15:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_req;
    logic [2:0]  voice_en;
    logic        load_en;
    logic [1:0]  load_idx;
    logic [19:0] load_step;
    logic [59:0] step_size;
    logic [2:0]  gen_next;
    logic [2:0]  voice_ready;
    logic [47:0] voice_sample;
    logic [15:0] mix_sample;
    logic        mix_valid;
    logic        busy;
    logic        overrun;
    logic        timeout_err;
    logic        err_clr;

    int   cyc = 0;
    int   t0 = 0;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic recording = 1'b0;
    int   sample_val [3];
    logic [2:0] resp_mask = 3'b111;
    logic [2:0] pipe1 = 3'b000;
    logic [2:0] pipe2 = 3'b000;
    ev_t  exp_q [$];
    ev_t  obs_q [$];

    chord_scheduler #(.NUM_VOICES(NV), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_req   (sample_req),
        .voice_en     (voice_en),
        .load_en      (load_en),
        .load_idx     (load_idx),
        .load_step    (load_step),
        .step_size    (step_size),
        .gen_next     (gen_next),
        .voice_ready  (voice_ready),
        .voice_sample (voice_sample),
        .mix_sample   (mix_sample),
        .mix_valid    (mix_valid),
        .busy         (busy),
        .overrun      (overrun),
        .timeout_err  (timeout_err),
        .err_clr      (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sine readers answer two cycles after their gen_next pulse
    always @(posedge clk) begin
        pipe1 <= gen_next;
        pipe2 <= pipe1;
    end
    assign voice_ready  = pipe2 & resp_mask;
    assign voice_sample = {16'(sample_val[2]), 16'(sample_val[1]), 16'(sample_val[0])};

    // Record observable events relative to the request cycle
    always @(negedge clk) begin
        if (recording) begin
            if (gen_next != 3'b000) obs_q.push_back('{1'b0, 16'(cyc - t0), 16'(gen_next)});
            if (mix_valid)          obs_q.push_back('{1'b1, 16'(cyc - t0), mix_sample});
        end
    end

    function automatic logic [15:0] model_mix(input int sum);
        int q;
        q = sum;
`ifdef CHORD_SAT_EN
        if (q > 32767)  q = 32767;
        if (q < -32768) q = -32768;
`else
        q = q >>> 2;
`endif
        return 16'(q);
    endfunction

    // Expected event stream for one request with the given enables/responders
    task automatic predict(input logic [2:0] en, input logic [2:0] resp);
        int c;
        int sum;
        c = 1;
        sum = 0;
        for (int v = 0; v < NV; v++) begin
            if (en[v]) begin
                exp_q.push_back('{1'b0, 16'(c), 16'(1 << v)});
                if (resp[v]) begin
                    sum += sample_val[v];
                    c += 3;
                end else begin
                    c += 1 + TIMEOUT;
                end
            end
        end
        exp_q.push_back('{1'b1, 16'(c), model_mix(sum)});
    endtask

    task automatic start_req(input logic [2:0] en);
        @(posedge clk);
        #1;
        t0 = cyc;
        voice_en = en;
        sample_req = 1'b1;
        recording = 1'b1;
        @(posedge clk);
        #1;
        sample_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        recording = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        sample_req = 1'b0;
        voice_en = 3'b000;
        load_en = 1'b0;
        load_idx = 2'd0;
        load_step = 20'h0;
        err_clr = 1'b0;
        sample_val[0] = 0; sample_val[1] = 0; sample_val[2] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run += 7;
        if (gen_next !== 3'b000)  begin tests_failed++; $display("[TB] FAIL reset_gen_next got %b expected 000", gen_next); end
        if (mix_valid !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_mix_valid got %b expected 0", mix_valid); end
        if (busy !== 1'b0)        begin tests_failed++; $display("[TB] FAIL reset_busy got %b expected 0", busy); end
        if (overrun !== 1'b0)     begin tests_failed++; $display("[TB] FAIL reset_overrun got %b expected 0", overrun); end
        if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_timeout_err got %b expected 0", timeout_err); end
        if (step_size !== 60'h0)  begin tests_failed++; $display("[TB] FAIL reset_step_size got %h expected 0", step_size); end
        if (mix_sample !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_mix_sample got %h expected 0", mix_sample); end
        reset = 1'b1;
    endtask

    task automatic test_load_step();
        logic [59:0] expect_steps;
        logic [1:0]  idx_tab  [3] = '{2'd2, 2'd3, 2'd0};
        logic [19:0] step_tab [3] = '{20'h0ABCD, 20'hFFFFF, 20'h12345};
        expect_steps = 60'h0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            load_en = 1'b1;
            load_idx = idx_tab[k];
            load_step = step_tab[k];
            if (idx_tab[k] < 2'd3) expect_steps[idx_tab[k]*20 +: 20] = step_tab[k];
            @(posedge clk);
            #1;
            load_en = 1'b0;
            tests_run++;
            if (step_size !== expect_steps) begin
                tests_failed++;
                $display("[TB] FAIL load_step idx=%0d got %h expected %h", idx_tab[k], step_size, expect_steps);
            end
        end
    endtask

    task automatic test_chord();
        int   s [2][3] = '{'{1000, -200, 50}, '{-1234, 777, 4001}};
        logic ok;
        ev_t  e, o;
        for (int p = 0; p < 2; p++) begin
            for (int v = 0; v < 3; v++) sample_val[v] = s[p][v];
            resp_mask = 3'b111;
            predict(3'b111, 3'b111);
            start_req(3'b111);
            wait_idle(40, ok);
            tests_run++;
            if (!ok) begin tests_failed++; $display("[TB] FAIL chord_idle got busy expected idle within 40 cycles"); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (obs_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL chord_event got none expected kind=%0d cycle=%0d data=%h", e.kind, e.cycle, e.data);
                end else begin
                    o = obs_q.pop_front();
                    if (o !== e) begin
                        tests_failed++;
                        $display("[TB] FAIL chord_event got kind=%0d cycle=%0d data=%h expected kind=%0d cycle=%0d data=%h", o.kind, o.cycle, o.data, e.kind, e.cycle, e.data);
                    end
                end
            end
            tests_run++;
            if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL chord_extra got %0d events expected 0", obs_q.size()); obs_q.delete(); end
        end
    endtask

    task automatic test_reset_abort();
        ev_t e, o;
        sample_val[0] = 1000; sample_val[1] = -200; sample_val[2] = 50;
        resp_mask = 3'b111;
        exp_q.push_back('{1'b0, 16'd1, 16'h0001});
        exp_q.push_back('{1'b0, 16'd4, 16'h0002});
        start_req(3'b111);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        tests_run += 3;
        if (busy !== 1'b0)        begin tests_failed++; $display("[TB] FAIL abort_busy got %b expected 0", busy); end
        if (mix_sample !== 16'h0) begin tests_failed++; $display("[TB] FAIL abort_mix_sample got %h expected 0", mix_sample); end
        if (step_size !== 60'h0)  begin tests_failed++; $display("[TB] FAIL abort_step_size got %h expected 0", step_size); end
        repeat (8) @(negedge clk);
        recording = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL abort_event got none expected kind=%0d cycle=%0d data=%h", e.kind, e.cycle, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL abort_event got kind=%0d cycle=%0d data=%h expected kind=%0d cycle=%0d data=%h", o.kind, o.cycle, o.data, e.kind, e.cycle, e.data);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL abort_extra got %0d events expected 0", obs_q.size()); obs_q.delete(); end
    endtask

    task automatic test_sparse();
        logic [2:0] en_tab [2] = '{3'b010, 3'b000};
        logic ok;
        ev_t  e, o;
        sample_val[0] = 1000; sample_val[1] = -200; sample_val[2] = 50;
        resp_mask = 3'b111;
        for (int p = 0; p < 2; p++) begin
            predict(en_tab[p], 3'b111);
            start_req(en_tab[p]);
            wait_idle(40, ok);
            tests_run++;
            if (!ok) begin tests_failed++; $display("[TB] FAIL sparse_idle got busy expected idle within 40 cycles"); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (obs_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL sparse_event got none expected kind=%0d cycle=%0d data=%h", e.kind, e.cycle, e.data);
                end else begin
                    o = obs_q.pop_front();
                    if (o !== e) begin
                        tests_failed++;
                        $display("[TB] FAIL sparse_event got kind=%0d cycle=%0d data=%h expected kind=%0d cycle=%0d data=%h", o.kind, o.cycle, o.data, e.kind, e.cycle, e.data);
                    end
                end
            end
            tests_run++;
            if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL sparse_extra got %0d events expected 0", obs_q.size()); obs_q.delete(); end
        end
    endtask

    task automatic test_saturation();
        int   s [2][3] = '{'{30000, 30000, 0}, '{-30000, -30000, 0}};
        logic ok;
        ev_t  e, o;
        resp_mask = 3'b111;
        for (int p = 0; p < 2; p++) begin
            for (int v = 0; v < 3; v++) sample_val[v] = s[p][v];
            predict(3'b111, 3'b111);
            start_req(3'b111);
            wait_idle(40, ok);
            tests_run++;
            if (!ok) begin tests_failed++; $display("[TB] FAIL sat_idle got busy expected idle within 40 cycles"); end
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if (obs_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL sat_event got none expected kind=%0d cycle=%0d data=%h", e.kind, e.cycle, e.data);
                end else begin
                    o = obs_q.pop_front();
                    if (o !== e) begin
                        tests_failed++;
                        $display("[TB] FAIL sat_event got kind=%0d cycle=%0d data=%h expected kind=%0d cycle=%0d data=%h", o.kind, o.cycle, o.data, e.kind, e.cycle, e.data);
                    end
                end
            end
            tests_run++;
            if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL sat_extra got %0d events expected 0", obs_q.size()); obs_q.delete(); end
        end
    endtask

    task automatic test_timeout();
        logic ok;
        ev_t  e, o;
        sample_val[0] = 1000; sample_val[1] = -200; sample_val[2] = 50;
        resp_mask = 3'b101;
        tests_run++;
        if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_pre got %b expected 0", timeout_err); end
        predict(3'b111, 3'b101);
        start_req(3'b111);
        wait_idle(60, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL timeout_idle got busy expected idle within 60 cycles"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL timeout_event got none expected kind=%0d cycle=%0d data=%h", e.kind, e.cycle, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL timeout_event got kind=%0d cycle=%0d data=%h expected kind=%0d cycle=%0d data=%h", o.kind, o.cycle, o.data, e.kind, e.cycle, e.data);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL timeout_extra got %0d events expected 0", obs_q.size()); obs_q.delete(); end
        tests_run += 2;
        if (timeout_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL timeout_flag got %b expected 1", timeout_err); end
        if (overrun !== 1'b0)     begin tests_failed++; $display("[TB] FAIL timeout_overrun got %b expected 0", overrun); end
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        tests_run++;
        if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL timeout_clear got %b expected 0", timeout_err); end
        resp_mask = 3'b111;
    endtask

    task automatic test_overrun();
        logic ok;
        ev_t  e, o;
        sample_val[0] = 1000; sample_val[1] = -200; sample_val[2] = 50;
        resp_mask = 3'b111;
        predict(3'b111, 3'b111);
        start_req(3'b111);
        repeat (4) @(posedge clk);
        #1;
        sample_req = 1'b1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        sample_req = 1'b0;
        err_clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL overrun_set_wins got %b expected 1", overrun); end
        wait_idle(40, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("[TB] FAIL overrun_idle got busy expected idle within 40 cycles"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL overrun_event got none expected kind=%0d cycle=%0d data=%h", e.kind, e.cycle, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("[TB] FAIL overrun_event got kind=%0d cycle=%0d data=%h expected kind=%0d cycle=%0d data=%h", o.kind, o.cycle, o.data, e.kind, e.cycle, e.data);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL overrun_extra got %0d events expected 0", obs_q.size()); obs_q.delete(); end
        tests_run++;
        if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL overrun_sticky got %b expected 1", overrun); end
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL overrun_clear got %b expected 0", overrun); end
    endtask

    initial begin
        test_reset();
        test_load_step();
        test_chord();
        test_reset_abort();
        test_sparse();
        test_saturation();
        test_timeout();
        test_overrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/chord_scheduler.md
CHORD_SCHEDULER -- requirements
Module: chord_scheduler

Interface
REQ-001 Parameter NUM_VOICES, default 3, range 1..4: number of sine-reader voices sequenced.
REQ-002 Parameter TIMEOUT, default 4: maximum cycles from gen_next to voice_ready before the voice is faulted.
REQ-003 clk  in  1  the single clock domain; every register is clocked on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset: a 0 sampled on a clk rising edge resets the block.
REQ-005 sample_req  in  1  one-cycle pulse from the codec requesting the next mixed sample.
REQ-006 voice_en  in  NUM_VOICES  per-voice enable, captured when a request is accepted.
REQ-007 load_en / load_idx / load_step  in  1 / 2 / 20  write load_step into the step register selected by load_idx.
REQ-008 step_size  out  NUM_VOICES*20  registered per-voice phase step driven to each sine reader; voice i occupies bits [20i+19:20i].
REQ-009 gen_next  out  NUM_VOICES  one-hot, one-cycle generate pulse to the voice sine readers.
REQ-010 voice_ready / voice_sample  in  NUM_VOICES / NUM_VOICES*16  per-voice ready pulse and signed sample from the sine readers.
REQ-011 mix_sample / mix_valid  out  16 / 1  signed mixed sample, held stable until the next mix_valid pulse; one-cycle valid pulse.
REQ-012 busy, overrun, timeout_err  out  1 each  status outputs; err_clr  in  1  clears both sticky flags.

Function
REQ-013 States: IDLE, ISSUE, WAIT, DONE.
REQ-014 IDLE: on sample_req, capture voice_en, clear the 18-bit signed accumulator and the voice index, then go to ISSUE.
  - If no voice is enabled, go directly to DONE.
REQ-015 ISSUE: assert gen_next[idx] for exactly one cycle, clear the wait counter, then go to WAIT.
REQ-016 WAIT: on voice_ready[idx], add the sign-extended voice_sample[idx] to the accumulator in the same cycle.
  - Then go to ISSUE for the next enabled voice, or to DONE if none remains.
REQ-017 Disabled voices are skipped entirely: no gen_next pulse, so their phase is frozen.
REQ-018 Timing with sample_req in IDLE at cycle 0 and E enabled voices:
  - first gen_next at cycle 1;
  - each voice costs 3 cycles against a sine reader with 2-cycle ready latency;
  - mix_valid at cycle 3E+1, or at cycle 1 when E=0.
REQ-019 DONE: register the mix result into mix_sample, pulse mix_valid for one cycle, return to IDLE.
REQ-020 busy = 1 in every state except IDLE.
REQ-021 sample_req while busy is dropped and sets overrun (sticky); the current sequence is unaffected.
REQ-022 If voice_ready[idx] has not arrived TIMEOUT cycles after the gen_next pulse:
  - the voice contributes 0;
  - timeout_err is set (sticky);
  - the sequence advances as in REQ-016.
REQ-023 voice_ready on a non-selected voice, or in IDLE/ISSUE/DONE, is ignored.
REQ-024 load_en updates step_size on the next edge in any state.
  - A load_idx >= NUM_VOICES is ignored.
  - A new step takes effect at that voice's next gen_next.
REQ-025 err_clr clears both sticky flags on the next edge. A set event in the same cycle wins over err_clr.

Reset
REQ-026 On reset:
  - state IDLE;
  - step_size, mix_sample, accumulator, index and counters all 0;
  - gen_next, mix_valid, busy, overrun and timeout_err all 0.
REQ-027 Reset mid-sequence aborts without asserting mix_valid. Any in-flight voice_ready is then ignored.

Configuration
REQ-028 With CHORD_SAT_EN defined, the mix result is the accumulator saturated to [-32768, 32767].
REQ-029 Without CHORD_SAT_EN, the mix result is the accumulator arithmetically shifted right by 2, truncated to 16 bits.

Structure
REQ-030 Shared package chord_pkg holds:
  - the state enum;
  - constants STEP_W=20, SAMPLE_W=16, ACC_W=18;
  - the saturation limits.
REQ-031 One sub-module, mix_round, holds the accumulator-to-16-bit conversion, including the CHORD_SAT_EN selection. Everything else is flat.

Verification
REQ-032 Bench using a sine-reader model with 2-cycle ready latency; voices 0..2 enabled; samples 1000, -200, 50; macro undefined; sample_req at cycle 0.
  - Expect gen_next at cycles 1, 4, 7.
  - Expect mix_valid at cycle 10 with mix_sample = 212 (850>>>2).
REQ-033 Same sequence with CHORD_SAT_EN defined and samples 30000, 30000, 0 -> mix_sample = 32767. With samples -30000, -30000, 0 -> mix_sample = -32768.
REQ-034 voice_en = 3'b010 -> a single gen_next on bit 1 at cycle 1 and mix_valid at cycle 4. voice_en = 0 -> mix_valid at cycle 1 with mix_sample = 0.
REQ-035 Voice 1 never responds -> its contribution is 0, timeout_err = 1, and mix_valid is still produced. err_clr then clears the flag.
REQ-036 Second sample_req at cycle 5 -> overrun = 1 and exactly one mix_valid.
  - reset=0 at cycle 5 of a new sequence -> no mix_valid and busy = 0 on the next cycle.
  - load_en with load_idx=2 and load_step=20'h0ABCD -> step_size[59:40] = 20'h0ABCD on the next cycle.
